// File: rtl/config_bitstream_loader.sv
// Serial-to-parallel config master: assembles LSB-first MEM_SIZE-bit words and strobes each block in turn.
// MEM_SIZE+3 cycles per block with continuous bit_valid; bit_valid low stalls SHIFT indefinitely.
module config_bitstream_loader #(
  parameter int MEM_SIZE   = 16,
  parameter int NUM_BLOCKS = 8,
  parameter int BLK_BITS   = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic                  bit_ready,
  output logic [MEM_SIZE-1:0]   config_out,
  output logic [NUM_BLOCKS-1:0] comb_set_out,
  output logic [BLK_BITS-1:0]   blk_idx,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_BITS = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(MEM_SIZE - 1);
  localparam logic [BLK_BITS-1:0] LAST_BLK = BLK_BITS'(NUM_BLOCKS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    SETUP  = 3'd2,
    STROBE = 3'd3,
    HOLD   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [MEM_SIZE-1:0]     shreg_q, shreg_d;
  logic [CNT_BITS-1:0]     cnt_q, cnt_d;
  logic [BLK_BITS-1:0]     blk_q, blk_d;
  logic [MEM_SIZE-1:0]     cfg_q, cfg_d;
  logic [NUM_BLOCKS-1:0]   set_q, set_d;
  logic                    done_q, done_d;
  logic                    hs;
  logic                    last_bit;
  logic                    last_blk;
  logic [MEM_SIZE-1:0]     shifted;

  assign hs       = bit_valid && (state_q == SHIFT);
  assign last_bit = (cnt_q == LAST_BIT);
  assign last_blk = (blk_q == LAST_BLK);
  assign shifted  = (shreg_q >> 1) | (MEM_SIZE'(bit_in) << (MEM_SIZE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      blk_q   <= '0;
      cfg_q   <= '0;
      set_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      cfg_q   <= cfg_d;
      set_q   <= set_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_start) state_d = SHIFT;
      SHIFT:   if (hs && last_bit) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  state_d = HOLD;
      HOLD:    state_d = last_blk ? DONE : SHIFT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobe and done are computed one cycle ahead so the outputs come straight from flops.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    cfg_d   = cfg_q;
    set_d   = '0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          blk_d = '0;
          cnt_d = '0;
        end
      end
      SHIFT: begin
        if (hs) begin
          shreg_d = shifted;
          if (last_bit) begin
            cnt_d = '0;
            cfg_d = shifted;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      SETUP: set_d = NUM_BLOCKS'(1) << blk_q;
      HOLD: begin
        if (last_blk) done_d = 1'b1;
        else          blk_d  = blk_q + 1'b1;
      end
      DONE: blk_d = '0;
      default: ;
    endcase
  end

  assign bit_ready    = (state_q == SHIFT);
  assign busy         = (state_q != IDLE);
  assign config_out   = cfg_q;
  assign comb_set_out = set_q;
  assign blk_idx      = blk_q;
  assign done         = done_q;

endmodule

// File: tb/tb_config_bitstream_loader.sv
// Scoreboard bench for config_bitstream_loader: stimulus pushes expected strobes/done, a negedge monitor checks them.
module tb_config_bitstream_loader;

  localparam int MEM_SIZE   = 16;
  localparam int NUM_BLOCKS = 8;
  localparam int BLK_BITS   = 3;
  localparam int SESSION_LAT = NUM_BLOCKS * (MEM_SIZE + 3) + 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  cfg_start = 1'b0;
  logic                  bit_in = 1'b0;
  logic                  bit_valid = 1'b0;
  logic                  bit_ready;
  logic [MEM_SIZE-1:0]   config_out;
  logic [NUM_BLOCKS-1:0] comb_set_out;
  logic [BLK_BITS-1:0]   blk_idx;
  logic                  busy;
  logic                  done;

  config_bitstream_loader #(.MEM_SIZE(MEM_SIZE), .NUM_BLOCKS(NUM_BLOCKS)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .bit_in(bit_in),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .config_out(config_out),
    .comb_set_out(comb_set_out), .blk_idx(blk_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               blk;
    logic [MEM_SIZE-1:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   hs_total = 0;
  int   blk_hs = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor
  logic [MEM_SIZE-1:0] prev_cfg = '0;
  logic                prev_rdy = 1'b0;
  logic                post_vld = 1'b0;
  logic [MEM_SIZE-1:0] post_word = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      post_vld = 1'b0;
      blk_hs   = 0;
    end else begin
      if (bit_valid && bit_ready) begin
        blk_hs++;
        hs_total++;
      end
      if (post_vld) begin
        check("hold_cfg", config_out, post_word);
        check("hold_set_clear", comb_set_out, 0);
        check("hold_rdy", bit_ready, 0);
        post_vld = 1'b0;
      end
      if (comb_set_out != 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", comb_set_out, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("strobe_onehot", comb_set_out, 64'(1) << e.blk);
          check("strobe_cfg", config_out, e.word);
          check("setup_cfg", prev_cfg, e.word);
          check("strobe_blk_idx", blk_idx, e.blk);
          check("strobe_rdy", bit_ready, 0);
          check("setup_rdy", prev_rdy, 0);
          check("bits_before_strobe", blk_hs, MEM_SIZE);
          post_vld  = 1'b1;
          post_word = e.word;
        end
        blk_hs = 0;
      end
      if (done) begin
        done_cnt++;
        if (done_q.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          int lat;
          lat = done_q.pop_front();
          if (lat >= 0) check("done_latency", cyc - start_cyc, lat);
          check("done_blk_idx", blk_idx, NUM_BLOCKS - 1);
          check("done_rdy", bit_ready, 0);
          check("done_busy", busy, 1);
        end
      end
    end
    prev_cfg = config_out;
    prev_rdy = bit_ready;
  end

  // Stimulus
  task automatic send_bit(input logic b, input bit stall);
    bit hs;
    int n;
    n = 0;
    hs = 1'b0;
    bit_in = b;
    bit_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!hs && n < 1000) begin
      @(negedge clk);
      hs = bit_valid && bit_ready;
      @(posedge clk);
      #1;
      if (!hs) begin
        n++;
        if (stall) bit_valid = 1'($urandom_range(0, 1));
      end
    end
    if (!hs) check("bit_accept_timeout", hs, 1);
  endtask

  task automatic start_session();
    cfg_start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
  endtask

  task automatic run_session(input logic [MEM_SIZE-1:0] base, input bit stall, input bit poke);
    int hs0;
    logic [MEM_SIZE-1:0] w;
    hs0 = hs_total;
    for (int i = 0; i < NUM_BLOCKS; i++) exp_q.push_back('{blk: i, word: base + MEM_SIZE'(i)});
    done_q.push_back(stall ? -1 : SESSION_LAT);
    start_session();
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      w = base + MEM_SIZE'(i);
      for (int b = 0; b < MEM_SIZE; b++) begin
        if (poke && i == 2 && b == 5) cfg_start = 1'b1;
        send_bit(w[b], stall);
        cfg_start = 1'b0;
      end
    end
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      cfg_start = 1'b1;
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
    end
    repeat (6) @(posedge clk);
    #1;
    bit_valid = 1'b0;
    check("session_handshakes", hs_total - hs0, NUM_BLOCKS * MEM_SIZE);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MEM_SIZE-1:0] w;
    int hs0;
    // Reset and idle with data offered
    #1;
    check("reset_outputs", {config_out, comb_set_out, blk_idx, busy, done, bit_ready}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    hs0 = hs_total;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", {config_out, comb_set_out, blk_idx, busy, done, bit_ready}, 0);
    end
    check("idle_handshakes", hs_total - hs0, 0);
    @(posedge clk);
    #1;

    // Continuous, stalled, and start-poked sessions
    run_session(16'hA5C0, 1'b0, 1'b0);
    run_session(16'hA5C0, 1'b1, 1'b0);
    run_session(16'h5A30, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("no_second_session_busy", busy, 0);
    check("idle_blk_idx", blk_idx, 0);
    check("retained_cfg", config_out, 16'h5A37);
    @(posedge clk);
    #1;

    // Reset during the strobe of block 3
    for (int i = 0; i < 3; i++) exp_q.push_back('{blk: i, word: 16'hC300 + MEM_SIZE'(i)});
    start_session();
    for (int i = 0; i < 4; i++) begin
      w = 16'hC300 + MEM_SIZE'(i);
      for (int b = 0; b < MEM_SIZE; b++) send_bit(w[b], 1'b0);
    end
    @(posedge clk);
    #1;
    check("strobe_blk3_before_reset", comb_set_out, 8'h08);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_set_clear", comb_set_out, 0);
    check("async_reset_busy", busy, 0);
    bit_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("reset_drops_pending", exp_q.size(), 0);

    // Fresh session after reset starts at block 0
    run_session(16'h3C00, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("all_strobes_seen", exp_q.size(), 0);
    check("all_done_seen", done_q.size(), 0);
    check("done_count", done_cnt, 4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
